// File: rtl/cipher_byte_streamer_if.sv
// Byte-stream interface for cipher_byte_streamer.
//   iEncrypt_done : encryptor completion flag (pulse or level)
//   iCiphertext   : full ciphertext word, sampled on the capture cycle
//   iReady        : sink ready for the current byte
//   oData         : current byte (ciphertext byte or CRC trailer)
//   oValid        : oData is valid
//   oFirst        : marks ciphertext byte 0
//   oLast         : marks the CRC trailer byte
//   oBusy         : a frame is in progress
//   oOverrun      : sticky, a completion edge arrived while busy
// master = streamer side, slave = host/sink side.
interface cipher_byte_streamer_if #(
  parameter int MSG_SIZE = 512
);
  logic                iEncrypt_done;
  logic [MSG_SIZE-1:0] iCiphertext;
  logic                iReady;
  logic [7:0]          oData;
  logic                oValid;
  logic                oFirst;
  logic                oLast;
  logic                oBusy;
  logic                oOverrun;

  modport master (
    input  iEncrypt_done, iCiphertext, iReady,
    output oData, oValid, oFirst, oLast, oBusy, oOverrun
  );

  modport slave (
    output iEncrypt_done, iCiphertext, iReady,
    input  oData, oValid, oFirst, oLast, oBusy, oOverrun
  );
endinterface

// File: rtl/cipher_byte_streamer.sv
// cipher_byte_streamer
// Captures the ciphertext on a rising edge of the encryptor's done flag and
// streams it MSB byte first over a valid/ready handshake, followed by one
// CRC-8 trailer byte (init 0x00, MSB-first, no reflection, no final XOR).
// Ports:
//   iClk : system clock, rising edge
//   iRst : synchronous active-high reset
//   bus  : cipher_byte_streamer_if.master (done/ciphertext/ready in,
//          data/valid/first/last/busy/overrun out)
// All outputs come straight from flops.
module cipher_byte_streamer #(
  parameter int         MSG_SIZE = 512,
  parameter logic [7:0] CRC_POLY = 8'h07
) (
  input logic                      iClk,
  input logic                      iRst,
  cipher_byte_streamer_if.master   bus
);

  localparam int NBYTES = MSG_SIZE / 8;
  localparam int CNT_W  = $clog2(NBYTES) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC} state_t;

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    end
    return r;
  endfunction

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [7:0]          crc_q, crc_n;
  logic [MSG_SIZE-1:0] shadow_q, shadow_n;
  logic                done_q;
  logic                block_q;
  logic                overrun_q;
  logic [7:0]          data_q, data_n;
  logic                valid_q, valid_n;
  logic                first_q, first_n;
  logic                last_q, last_n;
  logic                busy_q, busy_n;
  logic                trigger;
  logic                accept;

  // block_q suppresses a done level that was already high while in reset;
  // it clears once done is seen low.
  assign trigger = bus.iEncrypt_done & ~done_q & ~block_q;
  assign accept  = valid_q & bus.iReady;

  // State / control registers
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      crc_q     <= '0;
      done_q    <= 1'b0;
      block_q   <= bus.iEncrypt_done;
      overrun_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      crc_q   <= crc_n;
      done_q  <= bus.iEncrypt_done;
      if (!bus.iEncrypt_done) block_q <= 1'b0;
      if (trigger && busy_q) overrun_q <= 1'b1;
      data_q  <= data_n;
      valid_q <= valid_n;
      first_q <= first_n;
      last_q  <= last_n;
      busy_q  <= busy_n;
    end
  end

  // Ciphertext shadow: data only, no reset needed
  always_ff @(posedge iClk) begin
    shadow_q <= shadow_n;
  end

  // Next-state logic; the shadow shifts left one byte per accepted byte so the
  // next byte to send is always at the top.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    crc_n    = crc_q;
    shadow_n = shadow_q;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_n  = S_DATA;
          cnt_n    = '0;
          crc_n    = '0;
          shadow_n = bus.iCiphertext;
        end
      end
      S_DATA: begin
        if (accept) begin
          crc_n    = crc8(crc_q, data_q);
          cnt_n    = cnt_q + CNT_W'(1);
          shadow_n = shadow_q << 8;
          if (cnt_q == LAST_IDX) state_n = S_CRC;
        end
      end
      S_CRC: begin
        if (accept) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    data_n  = data_q;
    valid_n = valid_q;
    first_n = first_q;
    last_n  = last_q;
    busy_n  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          data_n  = bus.iCiphertext[MSG_SIZE-1 -: 8];
          valid_n = 1'b1;
          first_n = 1'b1;
          last_n  = 1'b0;
          busy_n  = 1'b1;
        end
      end
      S_DATA: begin
        if (accept) begin
          first_n = 1'b0;
          if (cnt_q == LAST_IDX) begin
            data_n = crc_n;
            last_n = 1'b1;
          end else begin
            data_n = shadow_n[MSG_SIZE-1 -: 8];
          end
        end
      end
      S_CRC: begin
        if (accept) begin
          data_n  = '0;
          valid_n = 1'b0;
          last_n  = 1'b0;
          busy_n  = 1'b0;
        end
      end
      default: begin
        data_n  = '0;
        valid_n = 1'b0;
        first_n = 1'b0;
        last_n  = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.oData    = data_q;
  assign bus.oValid   = valid_q;
  assign bus.oFirst   = first_q;
  assign bus.oLast    = last_q;
  assign bus.oBusy    = busy_q;
  assign bus.oOverrun = overrun_q;

endmodule
